logic_fold: RTL and testbench

- Parametrised, sequential successor to the fixed 4-bit, 2-input bitwise XOR array.
- Folds a stream of WIDTH-bit words with a selectable bitwise operator over a frame of LEN words, and emits one result word per frame.
- Input and output both use valid/ready handshakes.
- Sits between board I/O (switch/header words) and downstream logic; maps to LUT4 plus DFF fabric on ice40.

---
 rtl/logic_pkg.sv | 5 +
 rtl/logic_op.sv | 13 +
 rtl/logic_fold.sv | 61 ++++++
 tb/tb_logic_fold.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// logic_pkg: shared operator and state encodings for the logic_fold block.
package logic_pkg;
    typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_XNOR = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/logic_op.sv
// logic_op: combinational WIDTH-bit bitwise operator selected by op.
module logic_op import logic_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_op == OP_AND ? i_a & i_b :
                 i_op == OP_OR  ? i_a | i_b :
                 i_op == OP_XOR ? i_a ^ i_b : ~(i_a ^ i_b);
endmodule

// File: rtl/logic_fold.sv
// logic_fold: folds a LEN-word frame with a selectable bitwise operator, one result per frame.
module logic_fold import logic_pkg::*; #(
    parameter int WIDTH  = 4,
    parameter int MAXLEN = 15,
    parameter int CNTW   = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       OP,
    input  logic [CNTW-1:0]  LEN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             BUSY
);
    state_e            r_state;
    op_e               r_op;
    logic [CNTW-1:0]   r_len;
    logic [CNTW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_acc;
    logic [CNTW-1:0]   w_eff_len;
    logic [WIDTH-1:0]  w_f;
    logic              w_in;
    logic              w_start;

    assign w_eff_len = LEN == '0 ? CNTW'(1) : LEN > CNTW'(MAXLEN) ? CNTW'(MAXLEN) : LEN;
    assign I_READY   = r_state == DONE ? O_READY : 1'b1;
    assign O_VALID   = r_state == DONE;
    assign O         = r_acc;
    assign BUSY      = r_state != IDLE;
    assign w_in      = I_VALID & I_READY;
    // An accepted word outside ACCUM always opens a frame; in DONE it implies the result left too.
    assign w_start   = w_in & (r_state != ACCUM);

    logic_op #(.WIDTH(WIDTH)) u_op (.i_op(r_op), .i_a(r_acc), .i_b(I), .o_y(w_f));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_op    <= OP_AND;
            r_len   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (w_start) begin
            r_op    <= op_e'(OP);
            r_len   <= w_eff_len;
            r_acc   <= I;
            r_cnt   <= CNTW'(1);
            r_state <= w_eff_len == CNTW'(1) ? DONE : ACCUM;
        end else if (r_state == ACCUM && w_in) begin
            r_acc   <= w_f;
            r_cnt   <= r_cnt + CNTW'(1);
            r_state <= r_cnt + CNTW'(1) == r_len ? DONE : ACCUM;
        end else if (r_state == DONE && O_READY) begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_logic_fold.sv
// tb_logic_fold: randomized and directed frames checked against a frame-level model and scoreboard.
module tb_logic_fold;
    logic       CLK = 0, RESET = 1, I_VALID = 0, O_READY = 1;
    logic [1:0] OP = 0;
    logic [3:0] LEN = 0, I = 0;
    logic       I_READY, O_VALID, BUSY;
    logic [3:0] O;

    logic_fold dut (.CLK(CLK), .RESET(RESET), .OP(OP), .LEN(LEN), .I(I), .I_VALID(I_VALID),
                    .I_READY(I_READY), .O(O), .O_VALID(O_VALID), .O_READY(O_READY), .BUSY(BUSY));

    always #5 CLK = ~CLK;

    int ncmp = 0, nfail = 0, nres = 0, cyc = 0;
    bit rand_rdy = 0;
    logic [3:0] sb[$];
    logic [3:0] w[16];
    logic [3:0] last_o = 0;

    int m_cnt = 0, m_len = 0;
    bit m_valid = 0;
    logic [1:0] m_op;
    logic [3:0] m_acc, m_val;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] fold(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00: return a & b;
            2'b01: return a | b;
            2'b10: return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic int eff(input logic [3:0] l);
        return l == 0 ? 1 : (l > 15 ? 15 : int'(l));
    endfunction

    always @(posedge CLK) cyc++;
    always @(posedge CLK) if (rand_rdy) #1 O_READY = 1'($urandom % 2);

    // Cycle monitor: transfers are decided by signals stable at the falling edge.
    always @(negedge CLK) begin
        if (RESET) begin
            chk("rst_ovalid", O_VALID, 0);
            chk("rst_busy", BUSY, 0);
            chk("rst_iready", I_READY, 1);
            m_cnt = 0;
            m_valid = 0;
            sb.delete();
        end else begin
            chk("o_valid", O_VALID, m_valid);
            chk("i_ready", I_READY, m_valid ? O_READY : 1'b1);
            chk("busy", BUSY, m_valid || m_cnt != 0);
            if (m_valid) chk("o_hold", O, m_val);
            if (m_valid && O_READY) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else chk("o_result", O, sb.pop_front());
                last_o = O;
                nres++;
                m_valid = 0;
            end
            if (I_VALID && I_READY) begin
                if (m_cnt == 0) begin
                    m_op = OP;
                    m_len = eff(LEN);
                    m_acc = I;
                end else m_acc = fold(m_op, m_acc, I);
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_valid = 1;
                    m_val = m_acc;
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] len, input int n, input int gapmax, input bit keep);
        logic [3:0] acc;
        bit ok;
        int to;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(gapmax, 0)) begin
                I_VALID = 0;
                @(posedge CLK); #1;
            end
            I_VALID = 1;
            I = w[k];
            OP = k == 0 ? op : 2'($urandom);
            LEN = k == 0 ? len : 4'($urandom);
            to = 0;
            do begin
                @(negedge CLK);
                ok = I_READY;
                @(posedge CLK); #1;
                to++;
            end while (!ok && to < 100);
            if (!ok) chk("accept_timeout", 0, 1);
            acc = k == 0 ? w[0] : fold(op, acc, w[k]);
        end
        if (n == eff(len)) sb.push_back(acc);
        if (!keep) I_VALID = 0;
    endtask

    task automatic wait_res(input int target);
        int t = 0;
        while (nres < target && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        if (nres < target) chk("result_timeout", nres, target);
    endtask

    task automatic frame(input logic [1:0] op, input logic [3:0] len, input int n, input logic [3:0] exp);
        int base = nres;
        send(op, len, n, 0, 0);
        wait_res(base + 1);
        chk("literal", last_o, exp);
    endtask

    initial begin
        int c0, base;
        repeat (2) @(negedge CLK);
        chk("rst_o", O, 0);
        #2 RESET = 0;
        @(posedge CLK); #1;

        w[0] = 4'h3; w[1] = 4'h5;
        frame(2'b10, 2, 2, 4'h6);
        w[0] = 4'h1; w[1] = 4'h2; w[2] = 4'h4; w[3] = 4'h8;
        frame(2'b10, 4, 4, 4'hF);
        w[0] = 4'hF; w[1] = 4'hE; w[2] = 4'h7;
        frame(2'b00, 3, 3, 4'h6);
        w[0] = 4'h3; w[1] = 4'h5;
        frame(2'b11, 2, 2, 4'h9);
        w[0] = 4'hA;
        frame(2'b01, 0, 1, 4'hA);

        O_READY = 0;
        w[0] = 4'hC; w[1] = 4'h3;
        send(2'b10, 2, 2, 0, 0);
        repeat (3) begin
            @(negedge CLK);
            chk("bp_o", O, 4'hF);
            chk("bp_valid", O_VALID, 1);
            chk("bp_iready", I_READY, 0);
        end
        @(posedge CLK); #1;
        base = nres;
        O_READY = 1;
        wait_res(base + 1);
        chk("bp_literal", last_o, 4'hF);
        @(negedge CLK);
        chk("bp_idle", BUSY, 0);
        @(posedge CLK); #1;

        base = nres;
        c0 = cyc;
        w[0] = 4'h1; w[1] = 4'h2;
        send(2'b10, 2, 2, 0, 1);
        w[0] = 4'h4; w[1] = 4'h8;
        send(2'b10, 2, 2, 0, 0);
        chk("b2b_cycles", cyc - c0, 4);
        wait_res(base + 2);
        chk("b2b_literal", last_o, 4'hC);

        w[0] = 4'h9; w[1] = 4'h7;
        send(2'b10, 4, 2, 0, 0);
        chk("pre_rst_busy", BUSY, 1);
        #2 RESET = 1;
        #1;
        chk("arst_ovalid", O_VALID, 0);
        chk("arst_busy", BUSY, 0);
        @(negedge CLK);
        #2 RESET = 0;
        @(posedge CLK); #1;
        base = nres;
        w[0] = 4'h6; w[1] = 4'h6;
        frame(2'b10, 2, 2, 4'h0);
        chk("post_rst_count", nres, base + 1);

        rand_rdy = 1;
        for (int f = 0; f < 200; f++) begin
            logic [3:0] l = 4'($urandom);
            for (int k = 0; k < 16; k++) w[k] = 4'($urandom);
            send(2'($urandom), l, eff(l), $urandom_range(2, 0), 1'($urandom % 2));
        end
        I_VALID = 0;
        @(posedge CLK);
        rand_rdy = 0;
        #1 O_READY = 1;
        repeat (5) @(posedge CLK);
        #1 chk("drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
